// File: rtl/axil_reg_responder.sv
// axil_reg_responder: AXI4-Lite responder exposing a 4-word register file.
// Words 0-2 are read/write and also drive o_reg0..o_reg2. Word 3 is a
// read-only count of completed write commits.
// Optional build macro AXIL_REG_RESPONDER_SLVERR_EN: a write to word 3
// answers SLVERR instead of OKAY.
module axil_reg_responder #(
   parameter logic [31:0] C_RESET_W0 = 32'h0000_0000,
   parameter logic [31:0] C_RESET_W1 = 32'h0000_0000,
   parameter logic [31:0] C_RESET_W2 = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [3:0]  S_AXI_AWADDR,
   input  logic [2:0]  S_AXI_AWPROT,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   output logic [1:0]  S_AXI_BRESP,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   input  logic [3:0]  S_AXI_ARADDR,
   input  logic [2:0]  S_AXI_ARPROT,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic [31:0] o_reg0,
   output logic [31:0] o_reg1,
   output logic [31:0] o_reg2
);

   localparam logic [2:0][31:0] RESET_VALS = {C_RESET_W2, C_RESET_W1, C_RESET_W0};

   // Holding buffers for the write address and write data channels
   logic        aw_full_q, aw_full_d;
   logic [1:0]  aw_idx_q, aw_idx_d;
   logic        w_full_q, w_full_d;
   logic [31:0] w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;

   // Registered handshake outputs
   logic        awready_q, wready_q, arready_q;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;

   // Register file and commit counter
   logic [2:0][31:0] regs_q, regs_d;
   logic [2:0]       wr_en;
   logic [31:0]      wcnt_q, wcnt_d;

   logic        aw_hs, w_hs, ar_hs, r_hs, commit;
   logic [31:0] rd_word;

   // Protection bits and byte-offset bits carry no meaning for this block
   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign aw_hs  = S_AXI_AWVALID & awready_q;
   assign w_hs   = S_AXI_WVALID & wready_q;
   assign ar_hs  = S_AXI_ARVALID & arready_q;
   assign r_hs   = rvalid_q & S_AXI_RREADY;
   // A commit may retire the previous response on the same edge it is accepted
   assign commit = aw_full_q & w_full_q & (~bvalid_q | S_AXI_BREADY);

   // Byte-lane update of each writable word when the commit targets it
   for (genvar gi = 0; gi < 3; gi++) begin : g_word
      assign wr_en[gi] = commit & (aw_idx_q == 2'(gi));
      for (genvar bi = 0; bi < 4; bi++) begin : g_byte
         assign regs_d[gi][8*bi +: 8] = (wr_en[gi] & w_strb_q[bi]) ? w_data_q[8*bi +: 8]
                                                                    : regs_q[gi][8*bi +: 8];
      end
   end

   // Read mux: word 3 is the commit counter
   always_comb begin
      rd_word = wcnt_q;
      if (S_AXI_ARADDR[3:2] != 2'd3) begin
         rd_word = regs_q[S_AXI_ARADDR[3:2]];
      end
   end

   // Next-state for buffers, responses and the counter
   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      wcnt_d    = wcnt_q;

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end

      if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end
      if (commit) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         wcnt_d    = wcnt_q + 32'd1;
`ifdef AXIL_REG_RESPONDER_SLVERR_EN
         bresp_d   = (aw_idx_q == 2'd3) ? 2'b10 : 2'b00;
`else
         bresp_d   = 2'b00;
`endif
      end

      if (r_hs) begin
         rvalid_d = 1'b0;
      end
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_word;
      end
   end

   // State registers; READY outputs are registered copies of "buffer will be empty"
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         aw_full_q <= 1'b0;
         aw_idx_q  <= 2'd0;
         w_full_q  <= 1'b0;
         w_data_q  <= 32'd0;
         w_strb_q  <= 4'd0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         regs_q    <= RESET_VALS;
         wcnt_q    <= 32'd0;
      end else begin
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= ~aw_full_d;
         wready_q  <= ~w_full_d;
         arready_q <= ~rvalid_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         regs_q    <= regs_d;
         wcnt_q    <= wcnt_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign o_reg0        = regs_q[0];
   assign o_reg1        = regs_q[1];
   assign o_reg2        = regs_q[2];

endmodule

// File: tb/tb_axil_reg_responder.sv
// Testbench for axil_reg_responder: vector table of single reads/writes plus
// hand-written sequences for ordering, backpressure and reset corner cases.
module tb_axil_reg_responder;

   localparam logic [31:0] RST_W0 = 32'h0000_0000;
   localparam logic [31:0] RST_W1 = 32'hA5A5_0001;
   localparam logic [31:0] RST_W2 = 32'h1234_5678;
`ifdef AXIL_REG_RESPONDER_SLVERR_EN
   localparam logic [31:0] IDX3_RESP = 32'd2;
`else
   localparam logic [31:0] IDX3_RESP = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [3:0]  awaddr, araddr, wstrb;
   logic [2:0]  awprot, arprot;
   logic [31:0] wdata, rdata, o_reg0, o_reg1, o_reg2;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   axil_reg_responder #(
      .C_RESET_W0(RST_W0),
      .C_RESET_W1(RST_W1),
      .C_RESET_W2(RST_W2)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
      .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
      .o_reg0(o_reg0), .o_reg1(o_reg1), .o_reg2(o_reg2)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;   // read data for reads, BRESP for writes
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
      int  n = 0;
      bit  aw_done = 0, w_done = 0, aw_hs, w_hs;
      awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s; bready = 1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick(); n++;
         if (aw_hs) begin aw_done = 1; awvalid = 0; end
         if (w_hs)  begin w_done = 1;  wvalid = 0;  end
      end
      while (!bvalid && n < 40) begin tick(); n++; end
      if (!bvalid) begin
         n_vec++; n_err++;
         $display("FAIL write_timeout: got bvalid=0 expected bvalid=1 addr=%h", a);
      end
      resp = bresp;
      awvalid = 0; wvalid = 0;
      tick();
      bready = 0;
      $display("write addr=%h data=%08h strb=%b bresp=%0d", a, d, s, resp);
   endtask

   task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      arvalid = 1; araddr = a; rready = 1;
      while (!arready && n < 20) begin tick(); n++; end
      tick();
      arvalid = 0;
      while (!rvalid && n < 40) begin tick(); n++; end
      if (!rvalid) begin
         n_vec++; n_err++;
         $display("FAIL read_timeout: got rvalid=0 expected rvalid=1 addr=%h", a);
      end
      d = rdata; r = rresp;
      tick();
      rready = 0;
      $display("read  addr=%h rdata=%08h rresp=%0d", a, d, r);
   endtask

   logic [31:0] rd;
   logic [1:0]  rs, br;
   int          bcnt;

   initial begin
      tbl[0]  = '{0, 4'h0, 32'h0,          4'h0,    RST_W0};
      tbl[1]  = '{0, 4'h4, 32'h0,          4'h0,    RST_W1};
      tbl[2]  = '{0, 4'h8, 32'h0,          4'h0,    RST_W2};
      tbl[3]  = '{0, 4'hC, 32'h0,          4'h0,    32'd0};
      tbl[4]  = '{1, 4'h4, 32'hDEADBEEF,   4'hF,    32'd0};
      tbl[5]  = '{0, 4'h4, 32'h0,          4'h0,    32'hDEADBEEF};
      tbl[6]  = '{0, 4'hC, 32'h0,          4'h0,    32'd1};
      tbl[7]  = '{1, 4'h9, 32'hAABBCCDD,   4'b1000, 32'd0};
      tbl[8]  = '{0, 4'h8, 32'h0,          4'h0,    32'hAA345678};
      tbl[9]  = '{1, 4'h5, 32'hFFFFFFFF,   4'h0,    32'd0};
      tbl[10] = '{0, 4'h7, 32'h0,          4'h0,    32'hDEADBEEF};
      tbl[11] = '{0, 4'hC, 32'h0,          4'h0,    32'd3};

      awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
      arvalid = 0; araddr = 0; arprot = 0; rready = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_arready", arready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_o_reg0", o_reg0, RST_W0);
      chk("rst_o_reg1", o_reg1, RST_W1);
      chk("rst_o_reg2", o_reg2, RST_W2);
      rst_n = 1;
      tick();
      chk("post_rst_awready", awready, 1);
      chk("post_rst_wready", wready, 1);
      chk("post_rst_arready", arready, 1);

      // Vector table
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, br);
            chk($sformatf("vec%0d_bresp", i), {30'd0, br}, tbl[i].exp);
         end else begin
            do_read(tbl[i].addr, rd, rs);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
            chk($sformatf("vec%0d_rresp", i), {30'd0, rs}, 32'd0);
         end
      end
      chk("tbl_o_reg0", o_reg0, RST_W0);
      chk("tbl_o_reg1", o_reg1, 32'hDEADBEEF);
      chk("tbl_o_reg2", o_reg2, 32'hAA345678);

      // W three cycles ahead of AW, partial strobes onto word 0
      bready = 1;
      wvalid = 1; wdata = 32'h11223344; wstrb = 4'b0101;
      tick();
      wvalid = 0;
      for (int i = 0; i < 3; i++) begin
         chk("wfirst_wready_low", wready, 0);
         chk("wfirst_no_bvalid", bvalid, 0);
         tick();
      end
      chk("wfirst_awready", awready, 1);
      awvalid = 1; awaddr = 4'h0;
      tick();
      awvalid = 0;
      chk("wfirst_bvalid_lat0", bvalid, 0);
      chk("wfirst_o_reg0_old", o_reg0, RST_W0);
      bcnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) chk("wfirst_o_reg0", o_reg0, 32'h00220044);
         if (bvalid) bcnt++;
      end
      chk("wfirst_bvalid_count", bcnt, 1);
      $display("wfirst seq o_reg0=%08h bvalid_count=%0d", o_reg0, bcnt);

      // B backpressure: second write waits behind a held response
      bready = 0;
      awvalid = 1; awaddr = 4'h0; wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF;
      tick();
      awvalid = 0; wvalid = 0;
      chk("bp_bvalid_lat0", bvalid, 0);
      tick();
      chk("bp_bvalid_lat1", bvalid, 1);
      chk("bp_o_reg0", o_reg0, 32'h55AA55AA);
      awvalid = 1; awaddr = 4'h4; wvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF;
      tick();
      awvalid = 0; wvalid = 0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_bvalid", bvalid, 1);
         chk("bp_hold_bresp", bresp, 0);
         chk("bp_hold_o_reg1", o_reg1, 32'hDEADBEEF);
         chk("bp_hold_awready", awready, 0);
         if (i < 4) tick();
      end
      bready = 1;
      tick();
      chk("bp_second_bvalid", bvalid, 1);
      chk("bp_second_o_reg1", o_reg1, 32'h0BADF00D);
      tick();
      chk("bp_bvalid_drop", bvalid, 0);
      do_read(4'hC, rd, rs);
      chk("bp_count", rd, 32'd6);

      // Read held by RREADY=0 while the same word is committed on the AR edge
      bready = 1; rready = 0;
      awvalid = 1; awaddr = 4'h8; wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      tick();
      awvalid = 0; wvalid = 0;
      arvalid = 1; araddr = 4'h8;
      tick();
      arvalid = 0;
      chk("rd_hold_o_reg2_new", o_reg2, 32'hCAFEF00D);
      for (int i = 0; i < 4; i++) begin
         chk("rd_hold_rvalid", rvalid, 1);
         chk("rd_hold_rdata", rdata, 32'hAA345678);
         chk("rd_hold_arready", arready, 0);
         if (i < 3) tick();
      end
      rready = 1;
      tick();
      rready = 0;
      chk("rd_hold_rvalid_drop", rvalid, 0);
      chk("rd_hold_arready_back", arready, 1);
      do_read(4'h8, rd, rs);
      chk("rd_hold_reread", rd, 32'hCAFEF00D);

      // Write to the read-only counter word
      do_write(4'hC, 32'hFFFFFFFF, 4'hF, br);
      chk("w3_bresp", {30'd0, br}, IDX3_RESP);
      do_read(4'hC, rd, rs);
      chk("w3_count", rd, 32'd8);
      do_read(4'h0, rd, rs);
      chk("w3_read_rresp", {30'd0, rs}, 32'd0);

      // Reset asserted with a B and an R response pending
      bready = 0; rready = 0;
      awvalid = 1; awaddr = 4'h0; wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
      arvalid = 1; araddr = 4'hC;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      tick();
      chk("mid_pre_bvalid", bvalid, 1);
      chk("mid_pre_rvalid", rvalid, 1);
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_bvalid", bvalid, 0);
      chk("mid_rst_rvalid", rvalid, 0);
      chk("mid_rst_awready", awready, 0);
      chk("mid_rst_arready", arready, 0);
      chk("mid_rst_rdata", rdata, 0);
      chk("mid_rst_o_reg0", o_reg0, RST_W0);
      chk("mid_rst_o_reg2", o_reg2, RST_W2);
      tick();
      rst_n = 1;
      tick();
      do_read(4'hC, rd, rs);
      chk("mid_rst_count", rd, 32'd0);
      do_read(4'h4, rd, rs);
      chk("mid_rst_word1", rd, RST_W1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axil_reg_responder.md
Name: axil_reg_responder

Overview:
- AXI4-Lite subordinate (responder) on the far end of the core's 4-bit-address, 32-bit-data AXI-Lite master port.
- Implements a 4-word register file: words 0-2 read/write, word 3 a read-only completed-write counter.
- Words 0-2 are also driven out as parallel outputs, so the core can control FPGA-test logic and read back status over AXI.

Parameters:
- C_RESET_W0, 32'h0000_0000, reset value of register word 0
- C_RESET_W1, 32'h0000_0000, reset value of register word 1
- C_RESET_W2, 32'h0000_0000, reset value of register word 2

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  reset, asynchronous assert, active-low
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_AWADDR  in  4  write byte address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_BRESP  out  2  write response
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_ARADDR  in  4  read byte address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- o_reg0, o_reg1, o_reg2  out  32 each  current register contents

Behaviour:
- Reset (i_reset_n=0, asynchronous): all READY/VALID outputs 0; BRESP, RRESP, RDATA 0; word0-2 set to C_RESET_W0-2; word3 (write counter) 0; AW and W holding buffers empty. Outputs leave reset values on the first edge after deassertion.
- Decode: word index = ADDR[3:2]; ADDR[1:0] ignored.
- Write path, two independent one-entry holding buffers (AW and W):
  - AWREADY = AW buffer empty; WREADY = W buffer empty. Both are registered outputs.
  - AW and W may arrive in either order or in the same cycle. Each is captured on its own handshake edge.
- Commit: on the first edge where both buffers are full and (!BVALID || BREADY):
  - for idx 0-2, each byte b with WSTRB[b]=1 is updated; WSTRB=0 changes nothing;
  - idx 3 is not written;
  - word3 increments by 1 (mod 2^32) on every commit, including commits to idx 3;
  - both buffers clear; BVALID=1 with BRESP=2'b00.
- Write latency: AW and W together at edge N -> BVALID and the new register value visible after edge N+1. Sustained throughput is one write per 2 cycles.
- B backpressure: BVALID is held with BRESP stable until the BREADY handshake. While it is held, both buffers may fill but no commit happens. A commit is allowed on the same edge as the BREADY handshake.
- Read path:
  - ARREADY = !RVALID.
  - On the AR handshake edge: RDATA = word[ARADDR[3:2]] sampled before any same-edge commit (old value); RVALID=1; RRESP=2'b00.
  - RDATA/RRESP are held stable until RREADY. RVALID drops on the handshake edge, so ARREADY returns the following cycle.
- Read and write channels are fully independent; simultaneous read and write to the same word returns the pre-commit value.
- o_reg0-2 are driven directly from the register flops; no extra latency.
- Reset asserted mid-transaction aborts everything: buffered AW/W are discarded, pending B/R are dropped.

Optional Feature:
- Macro: AXIL_REG_RESPONDER_SLVERR_EN.
- Defined:
  - a write commit to idx 3 returns BRESP=2'b10 (SLVERR); word3 is still not written and still increments;
  - writes to idx 0-2 return OKAY;
  - reads always OKAY.
- Undefined: all responses are 2'b00.

Test Plan:
- Reset then read idx 0-3 (ARADDR 0,4,8,C), RREADY=1 -> RDATA = C_RESET_W0, W1, W2, then 0; RRESP=0; o_reg0-2 equal to reset values.
- AW=0x4 and W=0xDEADBEEF, WSTRB=4'hF, same cycle -> BVALID one cycle later, BRESP=0; o_reg1=0xDEADBEEF; read of 0x4 returns 0xDEADBEEF; word3 reads 1.
- W (0x11223344, WSTRB=4'b0101) three cycles before AW=0x0, word0=0 -> WREADY low until commit; word0=0x00220044; exactly one BVALID.
- BREADY held 0 for 5 cycles after first write, second AW/W offered -> BVALID/BRESP stable for 5 cycles; second commit on the BREADY edge; second BVALID next cycle; word3=2.
- Read of 0x8 with RREADY=0 for 4 cycles while writing 0xCAFEF00D to 0x8 -> RDATA stays at the old value, ARREADY=0 throughout; a later read returns 0xCAFEF00D.
- Write to 0xC with data 0xFFFFFFFF -> word3 = previous count + 1, not 0xFFFFFFFF; BRESP=2'b10 with AXIL_REG_RESPONDER_SLVERR_EN, 2'b00 without. Then assert i_reset_n=0 mid-write -> all VALIDs 0 immediately, word3=0.
